keypad_scan_fifo: RTL
=====================

# keypad_scan_fifo

Parametrised matrix-keypad scanner with debounce and a buffered key-event output. Drives one-hot column strobes and samples row returns. It debounces press and release and encodes the pressed key as row*NUM_COLS+col. Each debounced press is pushed into a small FIFO, which downstream logic drains through a valid/ready handshake. It replaces the fixed 4x4 single-key scanner that feeds the two-digit seven-segment display path: it adds arbitrary matrix size, configurable debounce, and event buffering with overflow reporting.

## Interface
- NUM_ROWS, 4, number of row inputs (>=1)
- NUM_COLS, 4, number of column strobes (>=2)
- SCAN_CYCLES, 4, clock cycles each column is driven while scanning (>=3)
- DEBOUNCE_CYCLES, 8, consecutive stable samples required for press and for release (>=2)
- FIFO_DEPTH, 4, key-event buffer entries (power of two, >=2)
- CODE_W, derived, $clog2(NUM_ROWS*NUM_COLS)
- int_osc  in  1  system clock
- nrst  in  1  asynchronous active-low reset; one clock
- row_d  in  NUM_ROWS  raw row returns, asynchronous, active-high (1 = key pressed on driven column)
- column_signals  out  NUM_COLS  one-hot active-high column strobe
- key_valid  out  1  FIFO head holds an event
- key_code  out  CODE_W  FIFO head key code, valid while key_valid
- key_ready  in  1  consumer accepts head when key_valid & key_ready
- any_pressed  out  1  FSM is in DEB_PRESS, HELD or DEB_REL
- overflow  out  1  sticky; set when a press is dropped because the FIFO is full; cleared only by reset

## Operation
- row_d passes through a 2-flop synchroniser (row_s). All decisions use row_s.
- FSM states: SCAN, DEB_PRESS, HELD, DEB_REL.
- SCAN:
  - Dwell counter runs 0..SCAN_CYCLES-1 on the current column.
  - Sample row_s only on the last dwell cycle.
  - If row_s==0, advance the column; it wraps NUM_COLS-1 -> 0.
  - Otherwise capture row_s into cap_row, clear the debounce counter, and go to DEB_PRESS. The column stays driven.
- DEB_PRESS:
  - Each cycle row_s==cap_row: increment the counter.
  - Any mismatch: go to SCAN, advance the column, reset dwell.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a match: push code = lowest set bit index of cap_row * NUM_COLS + col, then go to HELD.
- HELD: row_s==0 -> clear the counter and go to DEB_REL. Otherwise stay; no new events, including keys added while held.
- DEB_REL:
  - row_s==0 for DEBOUNCE_CYCLES consecutive cycles -> SCAN, advance the column, reset dwell.
  - Any nonzero sample -> HELD.
- Multiple rows on one column: the lowest row index wins and exactly one event is emitted.
- FIFO:
  - Push is dropped when full, and overflow is set the same cycle.
  - A simultaneous push and pop when full is accepted, so no overflow occurs.
  - A pop when empty is ignored.
  - Count range is 0..FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation:
  - All state clears immediately, the FIFO empties, and in-flight debounce is discarded.
  - After nrst rises, a key still held is re-detected as a fresh press and produces one new event.

## Timing
- Reset values:
  - column_signals = 1 (col 0)
  - key_valid = 0
  - key_code = 0
  - any_pressed = 0
  - overflow = 0
  - FSM = SCAN, dwell = 0
- All outputs are registered.
- Synchroniser latency is 2 cycles. SCAN_CYCLES>=3 guarantees row_s reflects the current column at the sample point.
- Push cycle = detection cycle + DEBOUNCE_CYCLES. key_valid rises the cycle after push when the FIFO was empty.
- key_code is stable while key_valid & !key_ready.
- After a pop, the next entry (if any) appears the following cycle.
- column_signals changes only on the cycle after an advance decision; exactly one bit is set at all times.

## Structure
- Package keypad_pkg:
  - state enum kp_state_t {SCAN, DEB_PRESS, HELD, DEB_REL}
  - function code_width(rows, cols)
  - function lowest_one(vector) returning the index
- Sub-module key_fifo:
  - parameters WIDTH, DEPTH
  - ports int_osc, nrst, push, push_data, pop, head_valid, head_data, full
  - instantiated once for the event buffer
- The scanner FSM, synchroniser and counters live in keypad_scan_fifo.

## Test plan
Common setup: defaults, 10 ns clock, nrst low 22 ns.

1. Single press: row_d=4'b0001 held while column 1 is driven, for 300 ns, then 0 for 300 ns. Exactly one event with key_code=1. any_pressed falls 8 cycles after release is seen. Scanning resumes at column 2.
2. Bounce: row_d toggles every 30 ns for 200 ns, then stays 4'b0010 on column 0. No event during toggling. Exactly one event with key_code=4 after stabilising.
3. Multi-row: row_d=4'b1010 on column 3. Exactly one event with key_code=7 (row 1). Adding row 0 while HELD produces no further event.
4. Overflow: key_ready=0; 5 distinct debounced presses (codes 0,5,10,15,1). FIFO holds 0,5,10,15 and overflow=1. Draining yields those four codes in order, then key_valid=0.
5. Full with simultaneous pop: FIFO full, key_ready=1 on the push cycle. overflow stays 0 and the order is preserved.
6. Reset mid-debounce: assert nrst during DEB_PRESS. All outputs return to reset values within one cycle. With the key still held, exactly one event follows after release of reset.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner and its event buffer.
// Latency: n/a (types and constant/combinational functions only).
// Backpressure: n/a.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } kp_state_t;

  // Width of a key code row*cols+col; never narrower than one bit.
  function automatic int code_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int lowest_one(input logic [31:0] vec);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small FIFO for key events with a registered head entry.
// Latency: a push into an empty FIFO is visible at the head the next cycle.
// Backpressure: pushes are dropped when full unless a pop is accepted the same cycle.
//
// Ports:
//   int_osc, nrst         clock, async active-low reset
//   push, push_data       write request and data (dropped when full without a pop)
//   pop                   consume head; ignored when empty
//   head_valid, head_data registered head entry
//   full                  count == DEPTH
module key_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             int_osc,
  input  logic             nrst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] head_next;
  logic             do_push, do_pop;

  assign full       = (count == CW'(DEPTH));
  assign do_pop     = pop & (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push    = push & (~full | do_pop);
  assign rd_next    = rd_ptr + PW'(do_pop);
  assign count_next = count + CW'(do_push) - CW'(do_pop);

  // Head register follows the read pointer; when the pushed word lands in
  // the slot that becomes the head, forward it instead of the stale memory.
  always_comb begin
    head_next = head_data;
    if (count_next != '0) begin
      if (do_push && (wr_ptr == rd_next)) head_next = push_data;
      else                                head_next = mem[rd_next];
    end
  end

  always_ff @(posedge int_osc) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge int_osc or negedge nrst) begin
    if (!nrst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      rd_ptr     <= rd_next;
      wr_ptr     <= wr_ptr + PW'(do_push);
      count      <= count_next;
      head_valid <= (count_next != '0);
      head_data  <= head_next;
    end
  end

endmodule

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner with press/release debounce feeding a key-event FIFO.
// Latency: event pushed DEBOUNCE_CYCLES after detection; visible on key_valid one cycle later.
// Backpressure: key_valid/key_ready handshake; presses arriving at a full FIFO are dropped and flagged on sticky overflow.
//
// Ports:
//   int_osc, nrst        clock, async active-low reset
//   row_d                raw async row returns (1 = key on driven column)
//   column_signals       one-hot column strobe
//   key_valid, key_code  FIFO head; key_ready pops it
//   any_pressed          scanner is debouncing or holding a key
//   overflow             sticky dropped-press flag
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter  int NUM_ROWS        = 4,
  parameter  int NUM_COLS        = 4,
  parameter  int SCAN_CYCLES     = 4,
  parameter  int DEBOUNCE_CYCLES = 8,
  parameter  int FIFO_DEPTH      = 4,
  localparam int CODE_W          = code_width(NUM_ROWS, NUM_COLS)
) (
  input  logic                int_osc,
  input  logic                nrst,
  input  logic [NUM_ROWS-1:0] row_d,
  output logic [NUM_COLS-1:0] column_signals,
  output logic                key_valid,
  output logic [CODE_W-1:0]   key_code,
  input  logic                key_ready,
  output logic                any_pressed,
  output logic                overflow
);

  localparam int COL_W   = $clog2(NUM_COLS);
  localparam int DWELL_W = $clog2(SCAN_CYCLES);
  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES);

  logic [NUM_ROWS-1:0] row_m, row_s;
  kp_state_t           state, state_nx;
  logic [DWELL_W-1:0]  dwell, dwell_nx;
  logic [DEB_W-1:0]    deb_cnt, deb_nx;
  logic [COL_W-1:0]    col, col_nx, col_adv;
  logic [NUM_ROWS-1:0] cap_row, cap_nx;
  logic                push, fifo_full, drop;
  logic [CODE_W-1:0]   push_code;

  assign col_adv   = (col == COL_W'(NUM_COLS - 1)) ? '0 : col + 1'b1;
  assign push_code = CODE_W'(lowest_one(32'(cap_row)) * NUM_COLS + int'(col));
  // Dropped only if the head is not leaving this same cycle.
  assign drop      = push & fifo_full & ~(key_valid & key_ready);

  always_comb begin
    state_nx = state;
    dwell_nx = dwell;
    deb_nx   = deb_cnt;
    col_nx   = col;
    cap_nx   = cap_row;
    push     = 1'b0;
    case (state)
      SCAN: begin
        // Sample only at the end of the dwell so the synchroniser has
        // settled on the current column's returns.
        if (dwell == DWELL_W'(SCAN_CYCLES - 1)) begin
          dwell_nx = '0;
          if (row_s == '0) begin
            col_nx = col_adv;
          end else begin
            cap_nx   = row_s;
            deb_nx   = '0;
            state_nx = DEB_PRESS;
          end
        end else begin
          dwell_nx = dwell + 1'b1;
        end
      end
      DEB_PRESS: begin
        if (row_s != cap_row) begin
          state_nx = SCAN;
          col_nx   = col_adv;
          dwell_nx = '0;
        end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          push     = 1'b1;
          state_nx = HELD;
        end else begin
          deb_nx = deb_cnt + 1'b1;
        end
      end
      HELD: begin
        if (row_s == '0) begin
          deb_nx   = '0;
          state_nx = DEB_REL;
        end
      end
      DEB_REL: begin
        if (row_s != '0) begin
          state_nx = HELD;
        end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          state_nx = SCAN;
          col_nx   = col_adv;
          dwell_nx = '0;
        end else begin
          deb_nx = deb_cnt + 1'b1;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  always_ff @(posedge int_osc or negedge nrst) begin
    if (!nrst) begin
      row_m          <= '0;
      row_s          <= '0;
      state          <= SCAN;
      dwell          <= '0;
      deb_cnt        <= '0;
      col            <= '0;
      cap_row        <= '0;
      column_signals <= {{(NUM_COLS-1){1'b0}}, 1'b1};
      any_pressed    <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      row_m          <= row_d;
      row_s          <= row_m;
      state          <= state_nx;
      dwell          <= dwell_nx;
      deb_cnt        <= deb_nx;
      col            <= col_nx;
      cap_row        <= cap_nx;
      column_signals <= {{(NUM_COLS-1){1'b0}}, 1'b1} << col_nx;
      any_pressed    <= (state_nx != SCAN);
      overflow       <= overflow | drop;
    end
  end

  key_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_key_fifo (
    .int_osc    (int_osc),
    .nrst       (nrst),
    .push       (push),
    .push_data  (push_code),
    .pop        (key_ready),
    .head_valid (key_valid),
    .head_data  (key_code),
    .full       (fifo_full)
  );

endmodule
